seven_segment_to_bcd_capture: RTL and testbench

- Reads a multiplexed, active-low, common-anode seven-segment display bus (segment lines plus per-digit anode selects) and turns each digit's segment pattern back into a BCD code.
- Filters scan transitions and glitches with a stability counter and assembles one BCD nibble per digit.
- Publishes a complete frame with a one-cycle valid pulse once every digit has been captured.
- Sits on the display side of the board, so the bench and self-check logic can read back what the seven-segment encoder path is actually driving.

---
 rtl/seven_segment_to_bcd_capture_if.sv | 19 +
 rtl/seven_segment_to_bcd_capture.sv | 112 +++++++++++
 tb/tb_seven_segment_to_bcd_capture.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seven_segment_to_bcd_capture_if.sv
// seven_segment_to_bcd_capture_if: display-side scan bus and captured-frame outputs
interface seven_segment_to_bcd_capture_if #(parameter int NUM_DIGITS = 4);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] frame_bcd;
    logic                    frame_valid;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    pattern_err;
    logic                    sel_err;
    modport master (
        output seg_in, an_in, clear,
        input  frame_bcd, frame_valid, digit_valid, pattern_err, sel_err
    );
    modport slave (
        input  seg_in, an_in, clear,
        output frame_bcd, frame_valid, digit_valid, pattern_err, sel_err
    );
endinterface

// File: rtl/seven_segment_to_bcd_capture.sv
// seven_segment_to_bcd_capture: debounces a multiplexed active-low 7-seg bus and rebuilds BCD frames
module seven_segment_to_bcd_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic rst_n,
    seven_segment_to_bcd_capture_if.slave bus
);
    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 4'h0;
            7'b1111001: decode = 4'h1;
            7'b0100100: decode = 4'h2;
            7'b0110000: decode = 4'h3;
            7'b0011001: decode = 4'h4;
            7'b0010010: decode = 4'h5;
            7'b0000010: decode = 4'h6;
            7'b1111000: decode = 4'h7;
            7'b0000000: decode = 4'h8;
            7'b0011000: decode = 4'h9;
            7'b1111111: decode = 4'hF;
            default:    decode = 4'hE;
        endcase
    endfunction

    logic [SW-1:0]           samp_q, samp_d, cur;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    committed_q, committed_d;
    logic [4*NUM_DIGITS-1:0] slot_q, slot_d, frame_bcd_q, frame_bcd_d;
    logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d, sel;
    logic                    frame_valid_q, frame_valid_d;
    logic                    pattern_err_q, pattern_err_d, sel_err_q, sel_err_d;
    logic                    same, commit;
    logic [3:0]              nib;

    always_comb begin
        cur           = {bus.an_in, bus.seg_in};
        same          = cur == samp_q;
        commit        = same && cnt_q == CNT_MAX && !committed_q;
        sel           = ~bus.an_in;
        nib           = decode(bus.seg_in);
        samp_d        = cur;
        cnt_d         = !same ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + CW'(1));
        committed_d   = same && (committed_q || commit);
        slot_d        = slot_q;
        digit_valid_d = digit_valid_q;
        frame_bcd_d   = frame_bcd_q;
        frame_valid_d = 1'b0;
        pattern_err_d = pattern_err_q;
        sel_err_d     = sel_err_q;
        // exactly one low anode means a real digit; all-high is blanking between digits
        if (commit && sel != '0 && (sel & (sel - NUM_DIGITS'(1))) == '0) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (sel[i]) begin
                    slot_d[4*i +: 4] = nib;
                    digit_valid_d[i] = 1'b1;
                end
            pattern_err_d = pattern_err_q | (nib == 4'hE);
            if (&digit_valid_d) begin
                frame_bcd_d   = slot_d;
                frame_valid_d = 1'b1;
                digit_valid_d = '0;
            end
        end else if (commit && sel != '0)
            sel_err_d = 1'b1;
        if (bus.clear) begin
            cnt_d         = '0;
            committed_d   = 1'b0;
            slot_d        = '1;
            digit_valid_d = '0;
            frame_bcd_d   = frame_bcd_q;
            frame_valid_d = 1'b0;
            pattern_err_d = 1'b0;
            sel_err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q        <= '0;
            cnt_q         <= '0;
            committed_q   <= 1'b0;
            slot_q        <= '1;
            digit_valid_q <= '0;
            frame_bcd_q   <= '1;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            samp_q        <= samp_d;
            cnt_q         <= cnt_d;
            committed_q   <= committed_d;
            slot_q        <= slot_d;
            digit_valid_q <= digit_valid_d;
            frame_bcd_q   <= frame_bcd_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign bus.frame_bcd   = frame_bcd_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.sel_err     = sel_err_q;
endmodule

// File: tb/tb_seven_segment_to_bcd_capture.sv
// tb_seven_segment_to_bcd_capture: directed scan sequences with a frame scoreboard
module tb_seven_segment_to_bcd_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    seven_segment_to_bcd_capture_if #(.NUM_DIGITS(4)) bus ();
    seven_segment_to_bcd_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic digit(input logic [3:0] an, input logic [6:0] seg);
        hold(an, seg, 6);
        hold(4'hF, 7'h7F, 2);
    endtask

    // every frame_valid pulse must match the oldest expected frame
    always @(negedge clk)
        if (rst_n && bus.frame_valid === 1'b1) begin
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL frame_unexpected observed %h expected no frame", bus.frame_bcd);
            end
            if (exp_q.size() > 0) chk("frame_scoreboard", 32'(bus.frame_bcd), 32'(exp_q.pop_front()));
        end

    initial begin
        bus.clear = 1'b0;
        repeat (2) begin
            bus.an_in  = 4'($urandom);
            bus.seg_in = 7'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_frame_bcd", 32'(bus.frame_bcd), 32'hFFFF);
        chk("rst_frame_valid", 32'(bus.frame_valid), 0);
        chk("rst_digit_valid", 32'(bus.digit_valid), 0);
        chk("rst_pattern_err", 32'(bus.pattern_err), 0);
        chk("rst_sel_err", 32'(bus.sel_err), 0);
        rst_n = 1'b1;

        digit(4'b1110, 7'b0010010);
        chk("scan_dv0", 32'(bus.digit_valid), 32'b0001);
        digit(4'b1101, 7'b0110000);
        chk("scan_dv1", 32'(bus.digit_valid), 32'b0011);
        digit(4'b1011, 7'b1111001);
        chk("scan_dv2", 32'(bus.digit_valid), 32'b0111);
        exp_q.push_back(16'h9135);
        hold(4'b0111, 7'b0011000, 5);
        chk("scan_frame_valid", 32'(bus.frame_valid), 1);
        chk("scan_frame_bcd", 32'(bus.frame_bcd), 32'h9135);
        chk("scan_dv_cleared", 32'(bus.digit_valid), 0);
        hold(4'b0111, 7'b0011000, 1);
        chk("scan_pulse_one", 32'(bus.frame_valid), 0);
        hold(4'hF, 7'h7F, 2);

        hold(4'b1110, 7'b0000000, 4);
        hold(4'hF, 7'h7F, 2);
        chk("stab_4_edges", 32'(bus.digit_valid), 0);
        hold(4'b1110, 7'b0000000, 5);
        chk("stab_5_edges", 32'(bus.digit_valid), 32'b0001);
        hold(4'b1110, 7'b0000000, 15);
        chk("stab_20_edges", 32'(bus.digit_valid), 32'b0001);
        hold(4'hF, 7'h7F, 2);
        digit(4'b1101, 7'b1111111);
        chk("blank_no_err", 32'(bus.pattern_err), 0);
        digit(4'b1011, 7'b1010101);
        chk("illegal_err", 32'(bus.pattern_err), 1);
        exp_q.push_back(16'h0EF8);
        digit(4'b0111, 7'b1000000);
        chk("err_frame_bcd", 32'(bus.frame_bcd), 32'h0EF8);
        chk("err_sticky", 32'(bus.pattern_err), 1);
        bus.clear = 1'b1;
        hold(4'hF, 7'h7F, 1);
        bus.clear = 1'b0;
        chk("clear_pattern_err", 32'(bus.pattern_err), 0);
        chk("clear_keeps_frame", 32'(bus.frame_bcd), 32'h0EF8);

        digit(4'b1110, 7'b1111001);
        hold(4'b1100, 7'b0100100, 10);
        chk("sel_err_set", 32'(bus.sel_err), 1);
        chk("sel_dv_kept", 32'(bus.digit_valid), 32'b0001);
        chk("sel_frame_kept", 32'(bus.frame_bcd), 32'h0EF8);
        bus.clear = 1'b1;
        hold(4'hF, 7'h7F, 1);
        bus.clear = 1'b0;
        chk("clear_sel_err", 32'(bus.sel_err), 0);
        chk("clear_dv", 32'(bus.digit_valid), 0);

        digit(4'b1110, 7'b0100100);
        digit(4'b1101, 7'b0011001);
        digit(4'b1011, 7'b0000010);
        chk("mid_dv", 32'(bus.digit_valid), 32'b0111);
        rst_n = 1'b0;
        hold(4'hF, 7'h7F, 1);
        rst_n = 1'b1;
        chk("mid_rst_dv", 32'(bus.digit_valid), 0);
        chk("mid_rst_frame", 32'(bus.frame_bcd), 32'hFFFF);

        digit(4'b1110, 7'b0100100);
        digit(4'b1101, 7'b0011001);
        digit(4'b1011, 7'b0000010);
        exp_q.push_back(16'h7642);
        digit(4'b0111, 7'b1111000);
        chk("frame2_bcd", 32'(bus.frame_bcd), 32'h7642);
        digit(4'b1110, 7'b0010010);
        digit(4'b1101, 7'b0110000);
        digit(4'b1011, 7'b1111001);
        hold(4'b0111, 7'b0011000, 4);
        bus.clear = 1'b1;
        hold(4'b0111, 7'b0011000, 1);
        bus.clear = 1'b0;
        chk("clr_commit_fv", 32'(bus.frame_valid), 0);
        chk("clr_commit_dv", 32'(bus.digit_valid), 0);
        chk("clr_commit_frame", 32'(bus.frame_bcd), 32'h7642);
        hold(4'hF, 7'h7F, 4);
        chk("frames_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
